// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin two-requester sequencer for a single-port 16x8 register file
// Ports: clock, reset_n (async, active-low); reqN_valid/write/addr/wdata in, reqN_ack/done/rdata out (N=0,1);
// rf_address/rf_en_write/rf_data_in drive the register file, rf_data_out is its registered read data;
// busy is high whenever the FSM is not in IDLE.
// Build option CLEAR_ON_RESET_EN: after reset, sweep zeros into all registers for 16 cycles before serving requests.
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_en_write,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;
  state_t state, state_n;
  logic ptr, ptr_n, lat_write, lat_write_n, lat_id, lat_id_n;
  logic ack0_n, ack1_n, done0_n, done1_n, en_n, grant1;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n, rdata0_n, rdata1_n;
`ifdef CLEAR_ON_RESET_EN
  logic clr_pend, clr_pend_n;
`endif
  // ptr=1 gives requester 1 priority when both are valid
  assign grant1 = req1_valid && (!req0_valid || ptr);
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    lat_write_n = lat_write;
    lat_id_n = lat_id;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    en_n = 1'b0;
    addr_n = rf_address;
    din_n = rf_data_in;
    rdata0_n = req0_rdata;
    rdata1_n = req1_rdata;
`ifdef CLEAR_ON_RESET_EN
    clr_pend_n = clr_pend;
`endif
    case (state)
      IDLE: begin
`ifdef CLEAR_ON_RESET_EN
        if (clr_pend) begin
          clr_pend_n = 1'b0;
          state_n = CLEAR;
          addr_n = '0;
          din_n = '0;
          en_n = 1'b1;
        end else
`endif
        if (req0_valid || req1_valid) begin
          state_n = ISSUE;
          ptr_n = !grant1;
          lat_id_n = grant1;
          lat_write_n = grant1 ? req1_write : req0_write;
          addr_n = grant1 ? req1_addr : req0_addr;
          din_n = grant1 ? req1_wdata : req0_wdata;
          en_n = lat_write_n;
          ack0_n = !grant1;
          ack1_n = grant1;
        end
      end
      ISSUE: begin
        state_n = lat_write ? IDLE : WAIT;
        done0_n = lat_write && !lat_id;
        done1_n = lat_write && lat_id;
      end
      WAIT: begin
        state_n = IDLE;
        done0_n = !lat_id;
        done1_n = lat_id;
        rdata0_n = lat_id ? req0_rdata : rf_data_out;
        rdata1_n = lat_id ? rf_data_out : req1_rdata;
      end
      CLEAR: begin
`ifdef CLEAR_ON_RESET_EN
        // address 0 was driven on entry; step up to the all-ones address, then stop and hold it
        en_n = rf_address != '1;
        addr_n = en_n ? rf_address + ADDR_W'(1) : rf_address;
        state_n = en_n ? CLEAR : IDLE;
`else
        state_n = IDLE;
`endif
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      lat_write <= 1'b0;
      lat_id <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      rf_address <= '0;
      rf_en_write <= 1'b0;
      rf_data_in <= '0;
      busy <= 1'b0;
`ifdef CLEAR_ON_RESET_EN
      clr_pend <= 1'b1;
`endif
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      lat_write <= lat_write_n;
      lat_id <= lat_id_n;
      req0_ack <= ack0_n;
      req1_ack <= ack1_n;
      req0_done <= done0_n;
      req1_done <= done1_n;
      req0_rdata <= rdata0_n;
      req1_rdata <= rdata1_n;
      rf_address <= addr_n;
      rf_en_write <= en_n;
      rf_data_in <= din_n;
      busy <= state_n != IDLE;
`ifdef CLEAR_ON_RESET_EN
      clr_pend <= clr_pend_n;
`endif
    end
  end
endmodule
